ahb_stream_loader: RTL and testbench



---
 rtl/ahb_stream_loader_pkg.sv | 20 ++
 rtl/ahb_stream_loader_byte_packer.sv | 32 +++
 rtl/ahb_stream_loader.sv | 134 +++++++++++++
 tb/tb_ahb_stream_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_stream_loader_pkg.sv
// Shared types and AHB-Lite constants
// for the byte-stream to AHB word loader.
package ahb_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/ahb_stream_loader_byte_packer.sv
// Little-endian byte-to-word packer: first
// byte lands in [7:0], fourth in [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (in_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {in_data, r_shift[31:8]};
    end
  end

  assign word       = r_shift;
  assign word_valid = in_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/ahb_stream_loader.sv
// Collects a byte stream into words and writes
// them as single AHB-Lite transfers.
module ahb_stream_loader
  import ahb_stream_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEMWIDTH  = 14
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [15:0] len_words,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IW = MEMWIDTH - 2;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_index;
  logic [15:0]     r_remain;
  logic [31:0]     r_haddr;
  logic [31:0]     r_hwdata;
  logic [31:0]     w_word;
  logic [31:0]     w_offset;
  logic            w_word_valid;
  logic            w_idle_eq;
  logic            w_start;
  logic            w_rx_fire;
  logic            w_wr_ok;

  assign w_idle_eq = (r_state == ST_IDLE) ||
                     (r_state == ST_DONE) ||
                     (r_state == ST_ERROR);
  assign w_start   = start && w_idle_eq;
  assign w_rx_fire = rx_valid && rx_ready;
  assign w_wr_ok   = (r_state == ST_DATA) &&
                     HREADY && !HRESP;
  assign w_offset  = {{(32-MEMWIDTH){1'b0}},
                      r_index, 2'b00};

  byte_packer u_packer (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .clear      (w_start),
    .in_valid   (w_rx_fire),
    .in_data    (rx_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start)
          w_next = (len_words == 16'd0) ?
                   ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_word_valid) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (HREADY) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (HRESP)
          w_next = ST_ERROR;
        else if (HREADY)
          w_next = (r_remain == 16'd1) ?
                   ST_DONE : ST_COLLECT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_index  <= '0;
      r_remain <= 16'd0;
      r_haddr  <= 32'd0;
      r_hwdata <= 32'd0;
    end else begin
      if (w_start) begin
        r_index  <= '0;
        r_remain <= len_words;
      end
      if ((r_state == ST_COLLECT) && w_word_valid)
        r_haddr <= BASE_ADDR + w_offset;
      // packer output is complete from the first ADDR cycle
      if (r_state == ST_ADDR)
        r_hwdata <= w_word;
      if (w_wr_ok) begin
        r_index  <= r_index + 1'b1;
        r_remain <= r_remain - 16'd1;
      end
    end
  end

  assign HADDR    = r_haddr;
  assign HWDATA   = r_hwdata;
  assign HTRANS   = (r_state == ST_ADDR) ?
                    HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE   = (r_state == ST_ADDR);
  assign HSIZE    = HSIZE_WORD;
  assign HBURST   = HBURST_SINGLE;
  assign HPROT    = HPROT_DATA;
  assign rx_ready = (r_state == ST_COLLECT);
  assign busy     = (r_state == ST_COLLECT) ||
                    (r_state == ST_ADDR) ||
                    (r_state == ST_DATA);
  assign done     = (r_state == ST_DONE);
  assign err      = (r_state == ST_ERROR);

endmodule

// File: tb/tb_ahb_stream_loader.sv
// Directed bench for ahb_stream_loader with a
// transaction-level write model and scoreboard.
module tb_ahb_stream_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MW   = 14;

  logic        HCLK, HRESETn, start;
  logic [15:0] len_words;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;
  logic        busy, done, err;

  logic        d4_rx_ready, d4_HWRITE;
  logic [31:0] d4_HADDR, d4_HWDATA;
  logic [1:0]  d4_HTRANS;
  logic [2:0]  d4_HSIZE, d4_HBURST;
  logic [3:0]  d4_HPROT;
  logic        d4_busy, d4_done, d4_err;

  ahb_stream_loader #(.BASE_ADDR(BASE), .MEMWIDTH(MW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .len_words(len_words), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .done(done), .err(err)
  );

  ahb_stream_loader #(.BASE_ADDR(BASE), .MEMWIDTH(4)) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .len_words(len_words), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(d4_rx_ready),
    .HADDR(d4_HADDR), .HTRANS(d4_HTRANS),
    .HWRITE(d4_HWRITE), .HSIZE(d4_HSIZE),
    .HBURST(d4_HBURST), .HPROT(d4_HPROT),
    .HWDATA(d4_HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(d4_busy), .done(d4_done), .err(d4_err)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int nonseq_cnt = 0;
  logic [7:0]  src_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] wlog[$];
  logic [31:0] q4[$];
  logic        rec4 = 0;
  logic        dphase = 0;
  logic        pend = 0;
  logic [31:0] a_addr = 0;

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(int idx);
    int words;
    words = 1 << (MW - 2);
    return BASE + 32'((idx % words) * 4);
  endfunction

  task automatic queue_word(logic [7:0] b0, logic [7:0] b1,
                            logic [7:0] b2, logic [7:0] b3,
                            int idx);
    src_q.push_back(b0);
    src_q.push_back(b1);
    src_q.push_back(b2);
    src_q.push_back(b3);
    exp_q.push_back({exp_addr(idx), b3, b2, b1, b0});
  endtask

  task automatic pulse(logic [15:0] n);
    @(negedge HCLK); #1;
    start = 1; len_words = n;
    @(negedge HCLK); #1;
    start = 0;
  endtask

  task automatic wait_end(int lim, string nm);
    int c = 0;
    while (!(done || err) && c < lim) begin
      @(negedge HCLK);
      c++;
    end
    chk(nm, {63'd0, done | err}, 64'd1);
  endtask

  task automatic wait_nonseq(int lim, string nm);
    int c = 0;
    @(negedge HCLK);
    while (HTRANS != 2'b10 && c < lim) begin
      @(negedge HCLK);
      c++;
    end
    chk(nm, {62'd0, HTRANS}, 64'd2);
  endtask

  task automatic chk_reset();
    chk("rst_htrans", {62'd0, HTRANS}, 64'd0);
    chk("rst_hwrite", {63'd0, HWRITE}, 64'd0);
    chk("rst_haddr", {32'd0, HADDR}, 64'd0);
    chk("rst_hwdata", {32'd0, HWDATA}, 64'd0);
    chk("rst_hsize", {61'd0, HSIZE}, 64'd2);
    chk("rst_hburst", {61'd0, HBURST}, 64'd0);
    chk("rst_hprot", {60'd0, HPROT}, 64'd3);
    chk("rst_status", {60'd0, rx_ready, busy, done, err},
        64'd0);
    chk("rst4_haddr", {32'd0, d4_HADDR}, 64'd0);
  endtask

  // byte source: pops a byte the cycle after it was taken
  initial begin
    rx_valid = 0;
    rx_data  = 0;
    forever begin
      @(negedge HCLK);
      if (pend && src_q.size() > 0)
        void'(src_q.pop_front());
      pend = 0;
      rx_valid = (src_q.size() > 0);
      rx_data  = rx_valid ? src_q[0] : 8'h00;
      pend = rx_valid && rx_ready;
    end
  end

  // scoreboard: sampled late in each cycle, before the edge
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge HCLK); #3;
      if (!HRESETn) begin
        dphase = 0;
        continue;
      end
      chk("inv_hwrite", {63'd0, HWRITE},
          {63'd0, HTRANS == 2'b10});
      chk("inv_ctrl", {54'd0, HSIZE, HBURST, HPROT},
          {54'd0, 3'b010, 3'b000, 4'b0011});
      chk("inv_status",
          {63'd0, ($countones({busy, done, err}) <= 1) &&
                  (!rx_ready || busy)}, 64'd1);
      if (dphase) begin
        if (HRESP) begin
          dphase = 0;
        end else if (HREADY) begin
          dphase = 0;
          wr_cnt++;
          wlog.push_back({a_addr, HWDATA});
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {a_addr, HWDATA}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("write", {a_addr, HWDATA}, e);
          end
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        nonseq_cnt++;
        dphase = 1;
        a_addr = HADDR;
      end
      if (rec4 && d4_HTRANS == 2'b10 && HREADY)
        q4.push_back(d4_HADDR);
    end
  end

  initial begin
    int w0, n0;
    int c;
    logic [31:0] a0;
    logic [31:0] wrap_exp[5];
    wrap_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    HRESETn = 0; start = 0; len_words = 0;
    HREADY = 1; HRESP = 0;
    repeat (2) @(negedge HCLK);
    chk_reset();
    #1 HRESETn = 1;

    // two words, zero wait states
    wlog.delete();
    queue_word(8'h11, 8'h22, 8'h33, 8'h44, 0);
    queue_word(8'h55, 8'h66, 8'h77, 8'h88, 1);
    pulse(2);
    wait_end(200, "t1_timeout");
    chk("t1_done_busy", {62'd0, done, busy}, 64'd2);
    chk("t1_pending", 64'(exp_q.size()), 64'd0);
    chk("t1_w0", wlog[0], {32'h0, 32'h44332211});
    chk("t1_w1", wlog[1], {32'h4, 32'h88776655});

    // address phase stalled three cycles
    w0 = wr_cnt;
    @(negedge HCLK); #1 HREADY = 0;
    queue_word(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);
    pulse(1);
    wait_nonseq(100, "t2_nonseq");
    a0 = HADDR;
    for (int i = 0; i < 4; i++) begin
      chk("t2_htrans_hold", {62'd0, HTRANS}, 64'd2);
      chk("t2_haddr_hold", {32'd0, HADDR}, {32'd0, a0});
      if (i < 3) @(negedge HCLK);
      else #1 HREADY = 1;
    end
    wait_end(50, "t2_timeout");
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t2_w", wlog[wlog.size()-1], {32'h0, 32'hEFBEADDE});

    // error response on the second data phase
    w0 = wr_cnt;
    queue_word(8'h01, 8'h02, 8'h03, 8'h04, 0);
    queue_word(8'h05, 8'h06, 8'h07, 8'h08, 1);
    queue_word(8'h09, 8'h0A, 8'h0B, 8'h0C, 2);
    pulse(3);
    c = 0;
    while (wr_cnt == w0 && c < 100) begin
      @(negedge HCLK);
      c++;
    end
    chk("t3_first_write", 64'(wr_cnt - w0), 64'd1);
    wait_nonseq(100, "t3_nonseq2");
    @(negedge HCLK); #1;
    HRESP = 1; HREADY = 0;
    @(negedge HCLK); #1;
    HRESP = 0; HREADY = 1;
    repeat (3) @(negedge HCLK);
    chk("t3_err", {61'd0, err, done, busy}, 64'd4);
    chk("t3_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("t3_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t3_unconsumed", 64'(src_q.size()), 64'd4);
    src_q.delete();
    exp_q.delete();

    // zero-length load
    n0 = nonseq_cnt;
    pulse(0);
    chk("t5_len0_done", {61'd0, done, err, busy}, 64'd4);
    repeat (3) @(negedge HCLK);
    chk("t5_len0_nonseq", 64'(nonseq_cnt - n0), 64'd0);

    // start while busy is ignored
    w0 = wr_cnt;
    pulse(1);
    repeat (3) @(negedge HCLK);
    chk("t5_busy", {63'd0, busy}, 64'd1);
    pulse(5);
    queue_word(8'hC1, 8'hC2, 8'hC3, 8'hC4, 0);
    wait_end(100, "t5_timeout");
    chk("t5_done", {63'd0, done}, 64'd1);
    n0 = nonseq_cnt;
    repeat (12) @(negedge HCLK);
    chk("t5_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t5_no_more", 64'(nonseq_cnt - n0), 64'd0);

    // five words; small instance wraps its index
    rec4 = 1;
    q4.delete();
    for (int i = 0; i < 5; i++)
      queue_word(8'(8'h20 + 4*i), 8'(8'h21 + 4*i),
                 8'(8'h22 + 4*i), 8'(8'h23 + 4*i), i);
    pulse(5);
    wait_end(400, "t4_timeout");
    rec4 = 0;
    chk("t4_done", {63'd0, done}, 64'd1);
    chk("t4_pending", 64'(exp_q.size()), 64'd0);
    chk("t4_last", wlog[wlog.size()-1],
        {32'h10, 32'h33323130});
    chk("t4_q4_len", 64'(q4.size()), 64'd5);
    for (int i = 0; i < 5 && i < q4.size(); i++)
      chk("t4_wrap_addr", {32'd0, q4[i]},
          {32'd0, wrap_exp[i]});

    // reset after two bytes of a word
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    pulse(1);
    c = 0;
    while ((src_q.size() != 0 || pend) && c < 50) begin
      @(negedge HCLK);
      c++;
    end
    chk("t6_partial", 64'(src_q.size()), 64'd0);
    @(negedge HCLK); #1 HRESETn = 0;
    #1 chk_reset();
    @(negedge HCLK); #1 HRESETn = 1;
    n0 = nonseq_cnt;
    repeat (4) @(negedge HCLK);
    chk("t6_idle", {62'd0, busy, done}, 64'd0);
    chk("t6_no_write", 64'(nonseq_cnt - n0), 64'd0);
    queue_word(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0);
    pulse(1);
    wait_end(100, "t6_timeout");
    chk("t6_word", wlog[wlog.size()-1],
        {32'h0, 32'hD4C3B2A1});
    chk("t6_pending", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
